// File: rtl/noc_pkg.sv
// Shared defaults and the width helper for the VC input buffer.
package noc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int NUM_VC_DEF = 4;

  // clog2 with a floor of one bit, so a field never ends up zero-width.
  function automatic int width_of(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vc_input_buffer_if.sv
// Write-side and output-side handshake bundle for vc_input_buffer.
// master: producer/consumer side, slave: the buffer itself.
interface vc_input_buffer_if
  import noc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_VC = NUM_VC_DEF
) ();

  localparam int VC_W  = width_of(NUM_VC);
  localparam int CNT_W = width_of(DEPTH) + 1;

  logic                    wr_en;
  logic [VC_W-1:0]         wr_vc;
  logic [DATA_W-1:0]       wr_data;
  logic [NUM_VC-1:0]       vc_full;
  logic                    out_valid;
  logic [VC_W-1:0]         out_vc;
  logic [DATA_W-1:0]       out_data;
  logic                    out_ready;
  logic [NUM_VC*CNT_W-1:0] vc_count;

  modport master (
    output wr_en, wr_vc, wr_data, out_ready,
    input  vc_full, out_valid, out_vc, out_data, vc_count
  );

  modport slave (
    input  wr_en, wr_vc, wr_data, out_ready,
    output vc_full, out_valid, out_vc, out_data, vc_count
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping at N-1.
// Returns an all-zero grant and index 0 when nothing requests.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   cand;

  // Scan N positions starting at ptr and take the first requester.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Virtual-channel input buffer: NUM_VC independent circular FIFOs sharing
// one output, arbitrated round-robin. rst_n is active-high and synchronous.
// Optional sticky drop flag (port err_flag) when VC_INPUT_BUFFER_ERR_EN is defined.
module vc_input_buffer
  import noc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_VC = NUM_VC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  vc_input_buffer_if.slave   bus
`ifdef VC_INPUT_BUFFER_ERR_EN
  ,
  output logic               err_flag
`endif
);

  localparam int VC_W  = width_of(NUM_VC);
  localparam int PTR_W = width_of(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr [NUM_VC];
  logic [CNT_W-1:0]  count  [NUM_VC];
  logic [VC_W-1:0]   rr_ptr;
  logic [VC_W-1:0]   grant_idx;
  logic [NUM_VC-1:0] req;
  logic [NUM_VC-1:0] grant_oh;
  logic [NUM_VC-1:0] push_vec;
  logic [NUM_VC-1:0] pop_vec;
  logic              pop;
  logic              wr_room;
  logic              wr_ok;

  // Per-VC status: request, full flag and packed occupancy.
  always_comb begin
    req          = '0;
    bus.vc_full  = '0;
    bus.vc_count = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      req[i]                        = (count[i] != '0);
      bus.vc_full[i]                = (count[i] == CNT_W'(DEPTH));
      bus.vc_count[i*CNT_W +: CNT_W] = count[i];
    end
  end

  rr_arbiter #(
    .N     (NUM_VC),
    .IDX_W (VC_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant_oh),
    .idx   (grant_idx)
  );

  assign bus.out_valid = |req;
  assign bus.out_vc    = grant_idx;
  assign bus.out_data  = mem[grant_idx][rd_ptr[grant_idx]];
  assign pop           = bus.out_valid & bus.out_ready;

  // Write acceptance: wr_vc must match a real VC (out-of-range never matches),
  // and that VC must have room or be draining one flit this same cycle.
  always_comb begin
    wr_room  = 1'b0;
    push_vec = '0;
    pop_vec  = grant_oh & {NUM_VC{pop}};
    for (int i = 0; i < NUM_VC; i++) begin
      if (bus.wr_vc == VC_W'(i))
        wr_room = (count[i] != CNT_W'(DEPTH)) || pop_vec[i];
    end
    wr_ok = bus.wr_en & wr_room;
    for (int i = 0; i < NUM_VC; i++)
      push_vec[i] = wr_ok && (bus.wr_vc == VC_W'(i));
  end

  // Pointers, counts and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (push_vec[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop_vec[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push_vec[i], pop_vec[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      if (pop)
        rr_ptr <= (int'(grant_idx) == NUM_VC - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Flit storage; contents are left stale across reset since counts gate them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VC; i++)
        if (push_vec[i]) mem[i][wr_ptr[i]] <= bus.wr_data;
    end
  end

`ifdef VC_INPUT_BUFFER_ERR_EN
  logic err_q;

  // Sticky record of any dropped write, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst_n)                       err_q <= 1'b0;
    else if (bus.wr_en && !wr_ok)    err_q <= 1'b1;
  end

  assign err_flag = err_q;
`endif

endmodule
